multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multicycle control FSM that sequences the shared datapath: one memory port, one ALU and the register file.
- Walks each instruction through fetch, decode, address/execute, memory and writeback steps.
- Emits per-cycle enables and mux selects.
- Stalls on a memory ready handshake and squashes instructions whose condition fails.

Parameters:
- PC_REGISTER, 4'b1111, register index treated as the program counter on writeback.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- operation  input  2  instruction op field (00 data-processing, 01 memory, 10 branch, 11 illegal)
- function  input  6  instruction funct field; bit5 = immediate, bit0 = load (memory) / set-flags (data-processing)
- destination  input  4  destination register index
- condition_met  input  1  condition check result, sampled in DECODE
- memory_ready  input  1  memory port completes the current access this cycle
- ir_write  output  1  load instruction register
- pc_update  output  1  write program counter
- address_source  output  1  0 = PC, 1 = ALU result register
- memory_read  output  1  read request
- write_memory  output  1  write request
- write_register  output  1  register file write enable
- write_flag  output  1  update NZCV flags
- ALU_source_a  output  2  00 = register A, 01 = PC
- ALU_source_b  output  2  00 = register B, 01 = extended immediate, 10 = constant 4
- ALU_operation  output  1  0 = add, 1 = decode from function
- result_source  output  2  00 = ALU result register, 01 = read data, 10 = ALU output direct
- illegal  output  1  one-cycle pulse on op 11

Behaviour:
- State encoding: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- Reset: asynchronous, active-low. The FSM enters FETCH. While reset_n is low, all outputs are 0.
- All outputs are a Moore function of state, except where gated by memory_ready, destination or function below.
- Unlisted outputs are 0.
- FETCH:
  - Outputs: memory_read=1, address_source=0, ALU_source_a=01, ALU_source_b=10, result_source=10.
  - ir_write and pc_update are both driven by memory_ready.
  - Stay in FETCH until memory_ready=1, then go to DECODE.
- DECODE:
  - Outputs: ALU_source_a=01, ALU_source_b=10, result_source=10 (computes PC+8).
  - condition_met=0: go to FETCH; the instruction is squashed with no side effects.
  - condition_met=1, operation 00: function[5]=1 goes to EXECI, otherwise EXECR.
  - condition_met=1, operation 01: go to MEMADR.
  - condition_met=1, operation 10: go to BRANCH.
  - Operation 11: illegal=1, go to FETCH (regardless of condition).
- MEMADR:
  - Outputs: ALU_source_a=00, ALU_source_b=01, ALU_operation=0.
  - function[0]=1 goes to MEMREAD, otherwise MEMWRITE.
- MEMREAD:
  - Outputs: memory_read=1, address_source=1.
  - Hold until memory_ready, then go to MEMWB.
- MEMWB:
  - Outputs: result_source=01, write_register=1.
  - pc_update=1 if destination==PC_REGISTER.
  - Next state: FETCH.
- MEMWRITE:
  - Outputs: write_memory=1, address_source=1.
  - Hold until memory_ready, then go to FETCH.
- EXECR:
  - Outputs: ALU_source_a=00, ALU_source_b=00, ALU_operation=1, write_flag=function[0].
  - Next state: ALUWB.
- EXECI:
  - Same as EXECR but ALU_source_b=01.
  - Next state: ALUWB.
- ALUWB:
  - Outputs: result_source=00, write_register=1.
  - pc_update=1 if destination==PC_REGISTER.
  - Next state: FETCH.
- BRANCH:
  - Outputs: ALU_source_a=00, ALU_source_b=01, result_source=10, pc_update=1.
  - Next state: FETCH.
- Latency in cycles, with memory_ready tied high:
  - Data-processing: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
  - Squashed instruction: 2.
- Each memory-ready wait cycle adds one cycle to the instruction.
- Reset during any state (including mid-stall) aborts immediately. No write or flag enable may be high in the cycle reset asserts.

Test Plan:
- Reset low for 2 cycles, release with memory_ready=1 → FETCH. memory_read=1, ir_write=1, pc_update=1 in the first cycle; all enables 0 during reset.
- op=00, function=6'b100001, destination=3, condition_met=1 → FETCH, DECODE, EXECI, ALUWB. write_flag=1 in EXECI; write_register=1 and pc_update=0 in ALUWB; returns to FETCH on cycle 5.
- op=01, function=6'b000001, memory_ready low for 2 cycles in MEMREAD, destination=15 → MEMREAD held 3 cycles. MEMWB asserts write_register=1 and pc_update=1.
- op=01, function=0 (store) → exactly one MEMWRITE cycle with write_memory=1 and address_source=1; write_register stays 0.
- op=10, condition_met=0 → DECODE returns to FETCH; pc_update in the BRANCH state never occurs. Then condition_met=1 → BRANCH pc_update=1.
- op=11 → illegal pulses for 1 cycle in DECODE, next state FETCH. reset_n asserted mid-MEMWRITE → write_memory drops to 0 asynchronously.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// The instruction's funct field is carried as `funct` because `function` is a reserved word.
interface multicycle_controller_if;
  logic [1:0] operation;
  logic [5:0] funct;
  logic [3:0] destination;
  logic       condition_met;
  logic       memory_ready;

  logic       ir_write;
  logic       pc_update;
  logic       address_source;
  logic       memory_read;
  logic       write_memory;
  logic       write_register;
  logic       write_flag;
  logic [1:0] ALU_source_a;
  logic [1:0] ALU_source_b;
  logic       ALU_operation;
  logic [1:0] result_source;
  logic       illegal;

  modport slave (
    input  operation, funct, destination, condition_met, memory_ready,
    output ir_write, pc_update, address_source, memory_read, write_memory,
           write_register, write_flag, ALU_source_a, ALU_source_b,
           ALU_operation, result_source, illegal
  );

  modport master (
    output operation, funct, destination, condition_met, memory_ready,
    input  ir_write, pc_update, address_source, memory_read, write_memory,
           write_register, write_flag, ALU_source_a, ALU_source_b,
           ALU_operation, result_source, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle control FSM sequencing one memory port, one ALU and the register file
// through fetch, decode, execute/address, memory and writeback steps.
module multicycle_controller #(
  parameter logic [3:0] PC_REGISTER = 4'b1111
) (
  input  logic                        clock,
  input  logic                        reset_n,
  multicycle_controller_if.slave      bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  state_t state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (bus.memory_ready) state <= DECODE;
        DECODE: begin
          // Illegal ops and failed conditions both retire with no side effects.
          if (bus.operation == 2'b11 || !bus.condition_met) begin
            state <= FETCH;
          end else begin
            case (bus.operation)
              2'b00:   state <= bus.funct[5] ? EXECI : EXECR;
              2'b01:   state <= MEMADR;
              default: state <= BRANCH;
            endcase
          end
        end
        MEMADR:   state <= bus.funct[0] ? MEMREAD : MEMWRITE;
        MEMREAD:  if (bus.memory_ready) state <= MEMWB;
        MEMWRITE: if (bus.memory_ready) state <= FETCH;
        EXECR:    state <= ALUWB;
        EXECI:    state <= ALUWB;
        default:  state <= FETCH;
      endcase
    end
  end

  logic       ir_w, pc_u, addr_s, mem_rd, mem_wr, reg_wr, flag_wr, alu_op, ill;
  logic [1:0] src_a, src_b, res_s;
  logic       dest_is_pc;
  logic       unused_funct_bits;

  assign dest_is_pc        = (bus.destination == PC_REGISTER);
  assign unused_funct_bits = ^bus.funct[4:1];

  always_comb begin
    ir_w    = 1'b0;
    pc_u    = 1'b0;
    addr_s  = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    reg_wr  = 1'b0;
    flag_wr = 1'b0;
    alu_op  = 1'b0;
    ill     = 1'b0;
    src_a   = 2'b00;
    src_b   = 2'b00;
    res_s   = 2'b00;
    case (state)
      FETCH: begin
        // PC+4 is written back in the same cycle the instruction word arrives.
        mem_rd = 1'b1;
        src_a  = 2'b01;
        src_b  = 2'b10;
        res_s  = 2'b10;
        ir_w   = bus.memory_ready;
        pc_u   = bus.memory_ready;
      end
      DECODE: begin
        src_a = 2'b01;
        src_b = 2'b10;
        res_s = 2'b10;
        ill   = (bus.operation == 2'b11);
      end
      MEMADR: begin
        src_b = 2'b01;
      end
      MEMREAD: begin
        mem_rd = 1'b1;
        addr_s = 1'b1;
      end
      MEMWB: begin
        res_s  = 2'b01;
        reg_wr = 1'b1;
        pc_u   = dest_is_pc;
      end
      MEMWRITE: begin
        mem_wr = 1'b1;
        addr_s = 1'b1;
      end
      EXECR, EXECI: begin
        src_b   = (state == EXECI) ? 2'b01 : 2'b00;
        alu_op  = 1'b1;
        flag_wr = bus.funct[0];
      end
      ALUWB: begin
        reg_wr = 1'b1;
        pc_u   = dest_is_pc;
      end
      BRANCH: begin
        src_b = 2'b01;
        res_s = 2'b10;
        pc_u  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Gating with reset_n forces every enable low the instant reset asserts.
  assign bus.ir_write       = reset_n & ir_w;
  assign bus.pc_update      = reset_n & pc_u;
  assign bus.address_source = reset_n & addr_s;
  assign bus.memory_read    = reset_n & mem_rd;
  assign bus.write_memory   = reset_n & mem_wr;
  assign bus.write_register = reset_n & reg_wr;
  assign bus.write_flag     = reset_n & flag_wr;
  assign bus.ALU_operation  = reset_n & alu_op;
  assign bus.illegal        = reset_n & ill;
  assign bus.ALU_source_a   = reset_n ? src_a : 2'b00;
  assign bus.ALU_source_b   = reset_n ? src_b : 2'b00;
  assign bus.result_source  = reset_n ? res_s : 2'b00;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each step queues inputs plus the
// expected control word, then compares the DUT's outputs one cycle at a time.
module tb_multicycle_controller;
  logic clock = 1'b0;
  logic reset_n = 1'b1;

  multicycle_controller_if bus();

  multicycle_controller #(.PC_REGISTER(4'b1111)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n;
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [3:0]  dst;
    logic        cond;
    logic        rdy;
    logic [14:0] exp;
  } step_t;

  step_t       stim_q[$];
  logic [14:0] sb_q[$];
  int          checks = 0;
  int          errors = 0;

  // Control word: {ir,pcu,asrc,mrd,mwr,wreg,wflg,srcA[2],srcB[2],aluop,res[2],ill}
  function automatic logic [14:0] ov(input logic ir, input logic pcu, input logic asrc,
                                     input logic mrd, input logic mwr, input logic wreg,
                                     input logic wflg, input logic [1:0] sa, input logic [1:0] sb,
                                     input logic aop, input logic [1:0] rs, input logic ill);
    return {ir, pcu, asrc, mrd, mwr, wreg, wflg, sa, sb, aop, rs, ill};
  endfunction

  function automatic logic [14:0] fx_fetch(input logic r);
    return ov(r, r, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 2'b10, 1'b0);
  endfunction
  function automatic logic [14:0] fx_decode(input logic i);
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 2'b10, i);
  endfunction
  function automatic logic [14:0] fx_memadr();
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0);
  endfunction
  function automatic logic [14:0] fx_memread();
    return ov(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
  endfunction
  function automatic logic [14:0] fx_memwb(input logic p);
    return ov(1'b0, p, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0);
  endfunction
  function automatic logic [14:0] fx_memwrite();
    return ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
  endfunction
  function automatic logic [14:0] fx_exec(input logic imm, input logic wf);
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, wf, 2'b00, imm ? 2'b01 : 2'b00, 1'b1, 2'b00, 1'b0);
  endfunction
  function automatic logic [14:0] fx_aluwb(input logic p);
    return ov(1'b0, p, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
  endfunction
  function automatic logic [14:0] fx_branch();
    return ov(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 2'b10, 1'b0);
  endfunction

  function automatic logic [14:0] observe();
    return {bus.ir_write, bus.pc_update, bus.address_source, bus.memory_read,
            bus.write_memory, bus.write_register, bus.write_flag, bus.ALU_source_a,
            bus.ALU_source_b, bus.ALU_operation, bus.result_source, bus.illegal};
  endfunction

  task automatic add(input logic r, input logic [1:0] op, input logic [5:0] fn,
                     input logic [3:0] dst, input logic cond, input logic rdy,
                     input logic [14:0] exp);
    step_t s;
    s.rst_n = r; s.op = op; s.fn = fn; s.dst = dst; s.cond = cond; s.rdy = rdy; s.exp = exp;
    stim_q.push_back(s);
  endtask

  task automatic drive(input step_t s);
    reset_n           = s.rst_n;
    bus.operation     = s.op;
    bus.funct         = s.fn;
    bus.destination   = s.dst;
    bus.condition_met = s.cond;
    bus.memory_ready  = s.rdy;
    sb_q.push_back(s.exp);
  endtask

  task automatic test_reset();
    step_t s; logic [14:0] obs, exp; int n = 0;
    add(1'b0, 2'b00, 6'd0, 4'd0, 1'b0, 1'b1, 15'd0);
    add(1'b0, 2'b00, 6'd0, 4'd0, 1'b0, 1'b1, 15'd0);
    add(1'b1, 2'b00, 6'd0, 4'd0, 1'b0, 1'b1, fx_fetch(1'b1));
    add(1'b1, 2'b00, 6'd0, 4'd0, 1'b0, 1'b1, fx_decode(1'b0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s);
      #1;
      obs = observe();
      exp = sb_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset cycle %0d: got %b expected %b", n, obs, exp);
      end
      n++;
      @(negedge clock);
    end
  endtask

  task automatic test_data_proc();
    step_t s; logic [14:0] obs, exp; int n = 0;
    add(1'b1, 2'b00, 6'b100001, 4'd3, 1'b1, 1'b1, fx_fetch(1'b1));
    add(1'b1, 2'b00, 6'b100001, 4'd3, 1'b1, 1'b1, fx_decode(1'b0));
    add(1'b1, 2'b00, 6'b100001, 4'd3, 1'b1, 1'b1, fx_exec(1'b1, 1'b1));
    add(1'b1, 2'b00, 6'b100001, 4'd3, 1'b1, 1'b1, fx_aluwb(1'b0));
    add(1'b1, 2'b00, 6'b100001, 4'd3, 1'b1, 1'b0, fx_fetch(1'b0));
    add(1'b1, 2'b00, 6'b000000, 4'd15, 1'b1, 1'b1, fx_fetch(1'b1));
    add(1'b1, 2'b00, 6'b000000, 4'd15, 1'b1, 1'b1, fx_decode(1'b0));
    add(1'b1, 2'b00, 6'b000000, 4'd15, 1'b1, 1'b1, fx_exec(1'b0, 1'b0));
    add(1'b1, 2'b00, 6'b000000, 4'd15, 1'b1, 1'b1, fx_aluwb(1'b1));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s);
      #1;
      obs = observe();
      exp = sb_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL data_proc cycle %0d: got %b expected %b", n, obs, exp);
      end
      n++;
      @(negedge clock);
    end
  endtask

  task automatic test_load();
    step_t s; logic [14:0] obs, exp; int n = 0;
    add(1'b1, 2'b01, 6'b000001, 4'd15, 1'b1, 1'b1, fx_fetch(1'b1));
    add(1'b1, 2'b01, 6'b000001, 4'd15, 1'b1, 1'b1, fx_decode(1'b0));
    add(1'b1, 2'b01, 6'b000001, 4'd15, 1'b1, 1'b1, fx_memadr());
    add(1'b1, 2'b01, 6'b000001, 4'd15, 1'b1, 1'b0, fx_memread());
    add(1'b1, 2'b01, 6'b000001, 4'd15, 1'b1, 1'b0, fx_memread());
    add(1'b1, 2'b01, 6'b000001, 4'd15, 1'b1, 1'b1, fx_memread());
    add(1'b1, 2'b01, 6'b000001, 4'd15, 1'b1, 1'b1, fx_memwb(1'b1));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s);
      #1;
      obs = observe();
      exp = sb_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL load cycle %0d: got %b expected %b", n, obs, exp);
      end
      n++;
      @(negedge clock);
    end
  endtask

  task automatic test_store();
    step_t s; logic [14:0] obs, exp; int n = 0;
    add(1'b1, 2'b01, 6'b000000, 4'd3, 1'b1, 1'b1, fx_fetch(1'b1));
    add(1'b1, 2'b01, 6'b000000, 4'd3, 1'b1, 1'b1, fx_decode(1'b0));
    add(1'b1, 2'b01, 6'b000000, 4'd3, 1'b1, 1'b1, fx_memadr());
    add(1'b1, 2'b01, 6'b000000, 4'd3, 1'b1, 1'b1, fx_memwrite());
    add(1'b1, 2'b01, 6'b000000, 4'd3, 1'b1, 1'b1, fx_fetch(1'b1));
    add(1'b1, 2'b01, 6'b000000, 4'd3, 1'b1, 1'b1, fx_decode(1'b0));
    add(1'b1, 2'b01, 6'b000000, 4'd3, 1'b1, 1'b1, fx_memadr());
    add(1'b1, 2'b01, 6'b000000, 4'd3, 1'b1, 1'b0, fx_memwrite());
    add(1'b1, 2'b01, 6'b000000, 4'd3, 1'b1, 1'b1, fx_memwrite());
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s);
      #1;
      obs = observe();
      exp = sb_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL store cycle %0d: got %b expected %b", n, obs, exp);
      end
      n++;
      @(negedge clock);
    end
  endtask

  task automatic test_branch();
    step_t s; logic [14:0] obs, exp; int n = 0;
    add(1'b1, 2'b10, 6'd0, 4'd0, 1'b0, 1'b1, fx_fetch(1'b1));
    add(1'b1, 2'b10, 6'd0, 4'd0, 1'b0, 1'b1, fx_decode(1'b0));
    add(1'b1, 2'b10, 6'd0, 4'd0, 1'b1, 1'b1, fx_fetch(1'b1));
    add(1'b1, 2'b10, 6'd0, 4'd0, 1'b1, 1'b1, fx_decode(1'b0));
    add(1'b1, 2'b10, 6'd0, 4'd0, 1'b1, 1'b1, fx_branch());
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s);
      #1;
      obs = observe();
      exp = sb_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL branch cycle %0d: got %b expected %b", n, obs, exp);
      end
      n++;
      @(negedge clock);
    end
  endtask

  task automatic test_illegal();
    step_t s; logic [14:0] obs, exp; int n = 0;
    add(1'b1, 2'b11, 6'd0, 4'd0, 1'b0, 1'b1, fx_fetch(1'b1));
    add(1'b1, 2'b11, 6'd0, 4'd0, 1'b0, 1'b1, fx_decode(1'b1));
    add(1'b1, 2'b11, 6'd0, 4'd0, 1'b1, 1'b1, fx_fetch(1'b1));
    add(1'b1, 2'b11, 6'd0, 4'd0, 1'b1, 1'b1, fx_decode(1'b1));
    add(1'b1, 2'b00, 6'd0, 4'd0, 1'b0, 1'b1, fx_fetch(1'b1));
    add(1'b1, 2'b00, 6'd0, 4'd0, 1'b0, 1'b1, fx_decode(1'b0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s);
      #1;
      obs = observe();
      exp = sb_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL illegal cycle %0d: got %b expected %b", n, obs, exp);
      end
      n++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid_write();
    step_t s; logic [14:0] obs, exp; int n = 0;
    add(1'b1, 2'b01, 6'd0, 4'd3, 1'b1, 1'b1, fx_fetch(1'b1));
    add(1'b1, 2'b01, 6'd0, 4'd3, 1'b1, 1'b1, fx_decode(1'b0));
    add(1'b1, 2'b01, 6'd0, 4'd3, 1'b1, 1'b1, fx_memadr());
    add(1'b1, 2'b01, 6'd0, 4'd3, 1'b1, 1'b0, fx_memwrite());
    add(1'b0, 2'b01, 6'd0, 4'd3, 1'b1, 1'b0, 15'd0);
    add(1'b0, 2'b01, 6'd0, 4'd3, 1'b1, 1'b1, 15'd0);
    add(1'b1, 2'b00, 6'd0, 4'd0, 1'b0, 1'b1, fx_fetch(1'b1));
    add(1'b1, 2'b00, 6'd0, 4'd0, 1'b0, 1'b1, fx_decode(1'b0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s);
      #1;
      obs = observe();
      exp = sb_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_mid_write cycle %0d: got %b expected %b", n, obs, exp);
      end
      n++;
      @(negedge clock);
    end
  endtask

  initial begin
    bus.operation     = 2'b00;
    bus.funct         = 6'd0;
    bus.destination   = 4'd0;
    bus.condition_met = 1'b0;
    bus.memory_ready  = 1'b0;
    test_reset();
    test_data_proc();
    test_load();
    test_store();
    test_branch();
    test_illegal();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
